jtbubl_shram_arb: RTL and testbench

//  N-port arbitrated shared RAM; parametrised successor of the two-CPU time-shared work RAM.

---
 rtl/jtbubl_shram_arb.sv | 127 ++++++++++++
 tb/tb_jtbubl_shram_arb.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtbubl_shram_arb.sv
// jtbubl_shram_arb: N-port arbitrated shared work RAM.
// One port owns the RAM at a time; the others are stalled through wait_n.
module jtbubl_shram_arb #(
   parameter int NPORTS = 2,
   parameter int AW     = 13,
   parameter int DW     = 8,
   parameter bit RROBIN = 1'b0
) (
   input  logic                 clk24,
   input  logic                 rst,
   input  logic [NPORTS-1:0]    port_rst,
   input  logic [NPORTS-1:0]    req_cs,
   input  logic [NPORTS-1:0]    req_we,
   input  logic [NPORTS*AW-1:0] req_addr,
   input  logic [NPORTS*DW-1:0] req_din,
   output logic [NPORTS*DW-1:0] port_dout,
   output logic [NPORTS-1:0]    wait_n,
   output logic [NPORTS-1:0]    grant,
   output logic                 busy
);

   if (NPORTS < 2 || NPORTS > 4) begin : g_bad_nports
      $error("jtbubl_shram_arb: NPORTS must be in 2..4");
   end

   typedef enum logic {IDLE, OWN} state_t;

   state_t            state, state_nxt;
   logic [NPORTS-1:0] eff_req, win, grant_nxt;
   logic [1:0]        last_owner, last_nxt, win_idx;
   logic              found, keep, rd_valid;
   logic [AW-1:0]     ram_addr;
   logic [DW-1:0]     ram_din, ram_q;
   logic              ram_we;
   logic [DW-1:0]     mem [2**AW];

   assign eff_req = req_cs & ~port_rst;
   assign keep    = |(grant & eff_req);
   assign busy    = |grant;
   assign wait_n  = ~(eff_req & ~(grant & {NPORTS{rd_valid}}));

   // Scan order i maps to port j; round-robin starts after the last owner
   always_comb begin
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < NPORTS; i++) begin
         for (int j = 0; j < NPORTS; j++) begin
            if (!found && eff_req[j] &&
                j == (RROBIN ? (int'(last_owner) + 1 + i) % NPORTS : i)) begin
               win[j]  = 1'b1;
               win_idx = 2'(j);
               found   = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      last_nxt  = last_owner;
      unique case (state)
         IDLE: begin
            if (found) begin
               state_nxt = OWN;
               grant_nxt = win;
               last_nxt  = win_idx;
            end
         end
         OWN: begin
            if (!keep) begin
               if (found) begin
                  grant_nxt = win;
                  last_nxt  = win_idx;
               end else begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk24 or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         last_owner <= 2'(NPORTS - 1);
         rd_valid   <= 1'b0;
         port_dout  <= '1;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_owner <= last_nxt;
         rd_valid   <= (|grant_nxt) && (grant_nxt == grant);
         for (int n = 0; n < NPORTS; n++) begin
            if (grant[n] && port_rst[n])
               port_dout[n*DW +: DW] <= '1;
            else if (grant[n] && rd_valid)
               port_dout[n*DW +: DW] <= ram_q;
         end
      end
   end

   always_comb begin
      ram_addr = '0;
      ram_din  = '0;
      ram_we   = 1'b0;
      for (int n = 0; n < NPORTS; n++) begin
         if (grant[n]) begin
            ram_addr = req_addr[n*AW +: AW];
            ram_din  = req_din[n*DW +: DW];
            ram_we   = req_we[n] & eff_req[n];
         end
      end
   end

   // Contents survive rst; the read port is idle when nobody owns the RAM
   always_ff @(posedge clk24) begin
      if (ram_we)
         mem[ram_addr] <= ram_din;
      if (busy)
         ram_q <= mem[ram_addr];
   end

endmodule

// File: tb/tb_jtbubl_shram_arb.sv
// tb_jtbubl_shram_arb: fixed-priority and round-robin 3-port instances
// driven with identical stimulus and checked against a cycle model.
module tb_jtbubl_shram_arb;

   logic        clk24 = 1'b0;
   logic        rst;
   logic [2:0]  port_rst, req_cs, req_we;
   logic [12:0] a [3];
   logic [7:0]  d [3];
   logic [38:0] req_addr;
   logic [23:0] req_din;
   logic [23:0] dout_f, dout_r;
   logic [2:0]  wn_f, wn_r, gr_f, gr_r;
   logic        busy_f, busy_r;

   int vec = 0;
   int bad = 0;

   int          own [2];
   int          age [2];
   int          last [2];
   logic [7:0]  qm [2];
   logic [7:0]  mdout [2][3];
   logic [7:0]  mmem [2][8192];

   assign req_addr = {a[2], a[1], a[0]};
   assign req_din  = {d[2], d[1], d[0]};

   always #5 clk24 = ~clk24;

   jtbubl_shram_arb #(.NPORTS(3), .AW(13), .DW(8), .RROBIN(1'b0)) u_fp (
      .clk24(clk24), .rst(rst), .port_rst(port_rst), .req_cs(req_cs),
      .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
      .port_dout(dout_f), .wait_n(wn_f), .grant(gr_f), .busy(busy_f)
   );

   jtbubl_shram_arb #(.NPORTS(3), .AW(13), .DW(8), .RROBIN(1'b1)) u_rr (
      .clk24(clk24), .rst(rst), .port_rst(port_rst), .req_cs(req_cs),
      .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
      .port_dout(dout_r), .wait_n(wn_r), .grant(gr_r), .busy(busy_r)
   );

   function automatic logic [2:0] eg(int m);
      return (own[m] >= 0) ? 3'(1 << own[m]) : 3'b000;
   endfunction

   function automatic logic [2:0] ew(int m);
      logic [2:0] e, w;
      e = req_cs & ~port_rst;
      for (int n = 0; n < 3; n++)
         w[n] = !(e[n] && !(own[m] == n && age[m] >= 1));
      return w;
   endfunction

   function automatic logic [23:0] ed(int m);
      return {mdout[m][2], mdout[m][1], mdout[m][0]};
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         own[m]  = -1;
         age[m]  = 0;
         last[m] = 2;
         for (int n = 0; n < 3; n++) mdout[m][n] = 8'hFF;
      end
   endtask

   // m=0 fixed priority, m=1 round-robin; age counts edges since grant
   task automatic model_edge();
      logic [2:0] e;
      int o, w, k;
      e = req_cs & ~port_rst;
      for (int m = 0; m < 2; m++) begin
         o = own[m];
         if (o >= 0) begin
            if (port_rst[o]) mdout[m][o] = 8'hFF;
            else if (age[m] >= 1) mdout[m][o] = qm[m];
            qm[m] = mmem[m][a[o]];
            if (req_we[o] && e[o]) mmem[m][a[o]] = d[o];
         end
         if (o >= 0 && e[o]) begin
            age[m]++;
         end else begin
            w = -1;
            for (int i = 0; i < 3; i++) begin
               k = (m == 1) ? (last[m] + 1 + i) % 3 : i;
               if (w < 0 && e[k]) w = k;
            end
            own[m] = w;
            age[m] = 0;
            if (w >= 0) last[m] = w;
         end
      end
   endtask

   task automatic step();
      @(posedge clk24);
      model_edge();
      #1;
   endtask

   task automatic access(int p, logic w, logic [12:0] ad, logic [7:0] dt);
      int n = 0;
      a[p] = ad; d[p] = dt; req_we[p] = w; req_cs[p] = 1'b1;
      do begin
         step();
         n++;
      end while (!(own[0] == p && age[0] >= 1) && n < 40);
      if (n >= 40) begin
         vec++; bad++;
         $display("FAIL access_timeout: port %0d not served in 40 cycles", p);
      end
      req_cs[p] = 1'b0; req_we[p] = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      #2;
      vec++;
      if (gr_f !== 3'b000 || gr_r !== 3'b000) begin
         bad++; $display("FAIL reset_grant: got %b/%b exp 000", gr_f, gr_r);
      end
      vec++;
      if (busy_f !== 1'b0 || busy_r !== 1'b0) begin
         bad++; $display("FAIL reset_busy: got %b/%b exp 0", busy_f, busy_r);
      end
      vec++;
      if (dout_f !== 24'hFFFFFF || dout_r !== 24'hFFFFFF) begin
         bad++; $display("FAIL reset_dout: got %h/%h exp ffffff", dout_f, dout_r);
      end
      vec++;
      if (wn_f !== 3'b111 || wn_r !== 3'b111) begin
         bad++; $display("FAIL reset_wait: got %b/%b exp 111", wn_f, wn_r);
      end
      repeat (2) @(posedge clk24);
      @(negedge clk24) rst = 1'b0;
   endtask

   task automatic test_preload();
      for (int i = 0; i < 16; i++) access(0, 1'b1, 13'(i), 8'(8'h30 + i));
      access(0, 1'b1, 13'h0123, 8'h00);
      access(0, 1'b1, 13'h1FFF, 8'h00);
      access(0, 1'b0, 13'h0003, 8'h00);
      vec++;
      if (dout_f[7:0] !== 8'h33 || dout_r[7:0] !== 8'h33) begin
         bad++; $display("FAIL preload_read: got %h/%h exp 33", dout_f[7:0], dout_r[7:0]);
      end
   endtask

   task automatic test_single_read();
      access(0, 1'b1, 13'h0123, 8'h5A);
      a[0] = 13'h0123; req_we[0] = 1'b0; req_cs[0] = 1'b1;
      #1;
      vec++;
      if (wn_f[0] !== 1'b0 || wn_r[0] !== 1'b0) begin
         bad++; $display("FAIL t1_wait_cs: got %b/%b exp 0", wn_f[0], wn_r[0]);
      end
      step();
      vec++;
      if (gr_f !== 3'b001 || gr_r !== 3'b001) begin
         bad++; $display("FAIL t1_grant: got %b/%b exp 001", gr_f, gr_r);
      end
      vec++;
      if (wn_f[0] !== 1'b0 || wn_r[0] !== 1'b0) begin
         bad++; $display("FAIL t1_wait_first: got %b/%b exp 0", wn_f[0], wn_r[0]);
      end
      step();
      vec++;
      if (wn_f[0] !== 1'b1 || wn_r[0] !== 1'b1) begin
         bad++; $display("FAIL t1_wait_rel: got %b/%b exp 1", wn_f[0], wn_r[0]);
      end
      req_cs[0] = 1'b0;
      step();
      vec++;
      if (dout_f[7:0] !== 8'h5A || dout_r[7:0] !== 8'h5A) begin
         bad++; $display("FAIL t1_data: got %h/%h exp 5a", dout_f[7:0], dout_r[7:0]);
      end
      vec++;
      if (busy_f !== 1'b0 || busy_r !== 1'b0) begin
         bad++; $display("FAIL t1_idle: got %b/%b exp 0", busy_f, busy_r);
      end
   endtask

   task automatic test_fixed_contention();
      a[0] = 13'h0005; a[1] = 13'h0006; req_we = 3'b000; req_cs = 3'b011;
      step();
      vec++;
      if (gr_f !== 3'b001) begin
         bad++; $display("FAIL t2_grant0: got %b exp 001", gr_f);
      end
      vec++;
      if (gr_r !== eg(1)) begin
         bad++; $display("FAIL t2_rr_grant: got %b exp %b", gr_r, eg(1));
      end
      repeat (3) begin
         step();
         vec++;
         if (wn_f[1] !== 1'b0 || gr_f !== 3'b001) begin
            bad++; $display("FAIL t2_hold: got wait %b grant %b exp 0/001", wn_f[1], gr_f);
         end
      end
      req_cs[0] = 1'b0;
      step();
      vec++;
      if (gr_f !== 3'b010) begin
         bad++; $display("FAIL t2_handover: got %b exp 010", gr_f);
      end
      step();
      vec++;
      if (wn_f[1] !== 1'b1) begin
         bad++; $display("FAIL t2_wait1: got %b exp 1", wn_f[1]);
      end
      req_cs = 3'b000;
      step();
      step();
   endtask

   task automatic test_top_addr();
      access(1, 1'b1, 13'h1FFF, 8'hA7);
      access(0, 1'b0, 13'h1FFF, 8'h00);
      vec++;
      if (dout_f[7:0] !== 8'hA7 || dout_r[7:0] !== 8'hA7) begin
         bad++; $display("FAIL t4_top: got %h/%h exp a7", dout_f[7:0], dout_r[7:0]);
      end
      access(0, 1'b0, 13'h0000, 8'h00);
      vec++;
      if (dout_f[7:0] !== 8'h30 || dout_r[7:0] !== 8'h30) begin
         bad++; $display("FAIL t4_zero: got %h/%h exp 30", dout_f[7:0], dout_r[7:0]);
      end
   endtask

   task automatic test_port_rst();
      a[0] = 13'h0123; req_we = 3'b000; req_cs[0] = 1'b1;
      step();
      step();
      a[1] = 13'h0005; req_cs[1] = 1'b1;
      step();
      vec++;
      if (dout_f[7:0] !== 8'h5A || dout_r[7:0] !== 8'h5A) begin
         bad++; $display("FAIL t5_pre: got %h/%h exp 5a", dout_f[7:0], dout_r[7:0]);
      end
      port_rst[0] = 1'b1;
      #1;
      vec++;
      if (wn_f[0] !== 1'b1 || wn_r[0] !== 1'b1) begin
         bad++; $display("FAIL t5_wait: got %b/%b exp 1", wn_f[0], wn_r[0]);
      end
      step();
      vec++;
      if (gr_f !== 3'b010 || gr_r !== 3'b010) begin
         bad++; $display("FAIL t5_grant: got %b/%b exp 010", gr_f, gr_r);
      end
      vec++;
      if (dout_f[7:0] !== 8'hFF || dout_r[7:0] !== 8'hFF) begin
         bad++; $display("FAIL t5_dout: got %h/%h exp ff", dout_f[7:0], dout_r[7:0]);
      end
      port_rst = 3'b000; req_cs = 3'b000;
      step();
      step();
   endtask

   task automatic test_rst_mid_write();
      a[2] = 13'h0005; d[2] = 8'h11; req_we[2] = 1'b1; req_cs[2] = 1'b1;
      step();
      vec++;
      if (gr_f !== 3'b100) begin
         bad++; $display("FAIL t6_own: got %b exp 100", gr_f);
      end
      rst = 1'b1; req_cs = 3'b000; req_we = 3'b000;
      model_reset();
      #1;
      vec++;
      if (gr_f !== 3'b000 || gr_r !== 3'b000 || busy_f !== 1'b0 || busy_r !== 1'b0) begin
         bad++; $display("FAIL t6_clear: got %b/%b busy %b/%b exp 000/0", gr_f, gr_r, busy_f, busy_r);
      end
      vec++;
      if (wn_f !== 3'b111 || wn_r !== 3'b111) begin
         bad++; $display("FAIL t6_wait: got %b/%b exp 111", wn_f, wn_r);
      end
      @(negedge clk24) rst = 1'b0;
      step();
      vec++;
      if (gr_f !== 3'b000 || wn_f !== 3'b111) begin
         bad++; $display("FAIL t6_after: got %b wait %b exp 000/111", gr_f, wn_f);
      end
      access(0, 1'b0, 13'h0005, 8'h00);
      vec++;
      if (dout_f[7:0] !== 8'h35 || dout_r[7:0] !== 8'h35) begin
         bad++; $display("FAIL t6_trunc: got %h/%h exp 35", dout_f[7:0], dout_r[7:0]);
      end
      access(0, 1'b0, 13'h0123, 8'h00);
      vec++;
      if (dout_f[7:0] !== 8'h5A || dout_r[7:0] !== 8'h5A) begin
         bad++; $display("FAIL t6_keep: got %h/%h exp 5a", dout_f[7:0], dout_r[7:0]);
      end
   endtask

   task automatic test_rr_order();
      logic [2:0] seq [$];
      logic [2:0] expq [6];
      logic [2:0] prev, got;
      int c = 0;
      rst = 1'b1;
      model_reset();
      #2 rst = 1'b0;
      for (int n = 0; n < 3; n++) a[n] = 13'(n + 1);
      req_we = 3'b000; req_cs = 3'b111; prev = 3'b000;
      while (seq.size() < 6 && c < 100) begin
         step();
         c++;
         vec++;
         if (gr_r !== eg(1)) begin
            bad++; $display("FAIL t3_rr_grant: got %b exp %b", gr_r, eg(1));
         end
         vec++;
         if (gr_f !== eg(0)) begin
            bad++; $display("FAIL t3_fp_grant: got %b exp %b", gr_f, eg(0));
         end
         if (gr_r !== prev && gr_r !== 3'b000) seq.push_back(gr_r);
         prev = gr_r;
         for (int n = 0; n < 3; n++) begin
            if (!req_cs[n]) req_cs[n] = 1'b1;
            else if (own[1] == n && age[1] >= 1) req_cs[n] = 1'b0;
         end
      end
      expq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      for (int i = 0; i < 6; i++) begin
         got = (i < seq.size()) ? seq[i] : 3'bxxx;
         vec++;
         if (got !== expq[i]) begin
            bad++; $display("FAIL t3_order[%0d]: got %b exp %b", i, got, expq[i]);
         end
      end
      req_cs = 3'b000;
      step();
      step();
   endtask

   task automatic test_random();
      logic [12:0] pool [18];
      for (int i = 0; i < 16; i++) pool[i] = 13'(i);
      pool[16] = 13'h0123;
      pool[17] = 13'h1FFF;
      for (int c = 0; c < 400; c++) begin
         for (int n = 0; n < 3; n++) begin
            req_cs[n]   = ($urandom_range(3) != 0);
            req_we[n]   = ($urandom_range(2) == 0);
            port_rst[n] = ($urandom_range(15) == 0);
            a[n]        = pool[$urandom_range(17)];
            d[n]        = 8'($urandom);
         end
         step();
         vec++;
         if (gr_f !== eg(0) || gr_r !== eg(1)) begin
            bad++; $display("FAIL rnd_grant@%0d: got %b/%b exp %b/%b", c, gr_f, gr_r, eg(0), eg(1));
         end
         vec++;
         if (busy_f !== |eg(0) || busy_r !== |eg(1)) begin
            bad++; $display("FAIL rnd_busy@%0d: got %b/%b exp %b/%b", c, busy_f, busy_r, |eg(0), |eg(1));
         end
         vec++;
         if (wn_f !== ew(0)) begin
            bad++; $display("FAIL rnd_wait_fp@%0d: got %b exp %b", c, wn_f, ew(0));
         end
         vec++;
         if (wn_r !== ew(1)) begin
            bad++; $display("FAIL rnd_wait_rr@%0d: got %b exp %b", c, wn_r, ew(1));
         end
         vec++;
         if (dout_f !== ed(0)) begin
            bad++; $display("FAIL rnd_dout_fp@%0d: got %h exp %h", c, dout_f, ed(0));
         end
         vec++;
         if (dout_r !== ed(1)) begin
            bad++; $display("FAIL rnd_dout_rr@%0d: got %h exp %h", c, dout_r, ed(1));
         end
      end
      req_cs = 3'b000; req_we = 3'b000; port_rst = 3'b000;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      port_rst = 3'b000; req_cs = 3'b000; req_we = 3'b000;
      for (int n = 0; n < 3; n++) begin
         a[n] = '0;
         d[n] = '0;
      end
      test_reset();
      test_preload();
      test_single_read();
      test_fixed_contention();
      test_top_addr();
      test_port_rst();
      test_rst_mid_write();
      test_rr_order();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
